frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_frame_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: steps an instruction address through a per-frame program,
// one instruction per dsp_clk cycle. Tracks completed frames and overruns,
// and switches program banks only at frame boundaries.
module frame_sequencer #(
    parameter int unsigned PC_WIDTH  = 11,
    parameter int unsigned BANK_BITS = 1,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned FREE_RUN  = 0
) (
    input  logic                          dsp_clk,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [PC_WIDTH:0]             prog_len,
    input  logic [BANK_BITS-1:0]          bank_req,
    input  logic                          bank_load,
    output logic [BANK_BITS+PC_WIDTH-1:0] instr_addr,
    output logic                          run,
    output logic                          frame_done,
    output logic                          overrun,
    output logic [CNT_WIDTH-1:0]          frame_count,
    output logic [CNT_WIDTH-1:0]          overrun_count,
    output logic [BANK_BITS-1:0]          active_bank
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam bit                  FreeRun = (FREE_RUN != 0);
    localparam logic [PC_WIDTH-1:0] PcOne   = PC_WIDTH'(1);
    localparam logic [PC_WIDTH:0]   LenOne  = (PC_WIDTH + 1)'(1);
    localparam logic [PC_WIDTH:0]   LenZero = '0;
    localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    state_e                state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic [PC_WIDTH:0]     len_q, len_d;
    logic [BANK_BITS-1:0]  bank_q, bank_d;
    logic [BANK_BITS-1:0]  pend_q, pend_d;
    logic                  done_q, done_d;
    logic                  ovr_q, ovr_d;
    logic [CNT_WIDTH-1:0]  fcnt_q, fcnt_d;
    logic [CNT_WIDTH-1:0]  ocnt_q, ocnt_d;

    logic                  at_last;
    logic                  start_evt;
    logic                  launch;
    logic                  count_inc;
    logic [BANK_BITS-1:0]  next_bank;

    // Frame-boundary decode: last instruction, start event and whether it launches a frame
    always_comb begin
        at_last   = (state_q == StRun) && ({1'b0, pc_q} == (len_q - LenOne));
        // In free-run mode the program end (or idling) stands in for frame_start
        if (FreeRun) begin
            start_evt = (state_q == StIdle) || at_last;
        end else begin
            start_evt = frame_start;
        end
        launch    = start_evt && (prog_len != LenZero);
        // Free-run counts only frames actually launched; otherwise every pulse counts
        count_inc = FreeRun ? launch : frame_start;
        // A bank_load coinciding with the start wins over the older pending request
        next_bank = bank_load ? bank_req : pend_q;
    end

    // Next-state logic for the sequencer FSM, counters and pulses
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        bank_d  = bank_q;
        pend_d  = bank_load ? bank_req : pend_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        fcnt_d  = count_inc ? (fcnt_q + CntOne) : fcnt_q;
        ocnt_d  = ocnt_q;

        unique case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d = StRun;
                    pc_d    = '0;
                    len_d   = prog_len;
                    bank_d  = next_bank;
                end
            end
            StRun: begin
                if (start_evt) begin
                    if (at_last) begin
                        done_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                        if (ocnt_q != CntMax) begin
                            ocnt_d = ocnt_q + CntOne;
                        end
                    end
                    if (launch) begin
                        pc_d   = '0;
                        len_d  = prog_len;
                        bank_d = next_bank;
                    end else begin
                        // Restart with an empty program: nothing to run, fall back to idle
                        state_d = StIdle;
                        pc_d    = '0;
                        len_d   = '0;
                    end
                end else if (at_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    pc_d = pc_q + PcOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge dsp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            len_q   <= '0;
            bank_q  <= '0;
            pend_q  <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            fcnt_q  <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            fcnt_q  <= fcnt_d;
            ocnt_q  <= ocnt_d;
        end
    end

    assign instr_addr    = {bank_q, pc_q};
    assign run           = (state_q == StRun);
    assign frame_done    = done_q;
    assign overrun       = ovr_q;
    assign frame_count   = fcnt_q;
    assign overrun_count = ocnt_q;
    assign active_bank   = bank_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: directed vector table, hand-written
// corner sequences, a free-running instance and randomized traffic against a model.
module tb_frame_sequencer;

    localparam int unsigned PW = 4;
    localparam int unsigned BB = 1;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              fs;
    logic [PW:0]       plen;
    logic [BB-1:0]     breq;
    logic              bload;
    logic [PW:0]       fr_len;

    logic [BB+PW-1:0]  addr, fr_addr;
    logic              run, done, ovr, fr_run, fr_done, fr_ovr;
    logic [CW-1:0]     fc, oc, fr_fc, fr_oc;
    logic [BB-1:0]     abank, fr_abank;

    frame_sequencer #(.PC_WIDTH(PW), .BANK_BITS(BB), .CNT_WIDTH(CW), .FREE_RUN(0)) dut (
        .dsp_clk(clk), .reset_n(reset_n), .frame_start(fs), .prog_len(plen),
        .bank_req(breq), .bank_load(bload), .instr_addr(addr), .run(run),
        .frame_done(done), .overrun(ovr), .frame_count(fc), .overrun_count(oc),
        .active_bank(abank)
    );

    frame_sequencer #(.PC_WIDTH(PW), .BANK_BITS(BB), .CNT_WIDTH(CW), .FREE_RUN(1)) dut_fr (
        .dsp_clk(clk), .reset_n(reset_n), .frame_start(fs), .prog_len(fr_len),
        .bank_req(breq), .bank_load(bload), .instr_addr(fr_addr), .run(fr_run),
        .frame_done(fr_done), .overrun(fr_ovr), .frame_count(fr_fc), .overrun_count(fr_oc),
        .active_bank(fr_abank)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs at the falling edge, let one rising edge pass, sample 1ns later
    task automatic cycle(input logic f, input logic [PW:0] l, input logic [BB-1:0] b,
                         input logic bl);
        @(negedge clk);
        fs = f; plen = l; breq = b; bload = bl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; fs = 1'b0; bload = 1'b0; breq = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic           fs;
        logic [PW:0]    len;
        logic [BB-1:0]  breq;
        logic           bload;
        logic [BB+PW-1:0] addr;
        logic           run;
        logic           done;
        logic           ovr;
        logic [CW-1:0]  fc;
        logic [CW-1:0]  oc;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic f, input int l, input int b, input logic bl, input int a,
                       input logic r, input logic d, input logic o, input int c, input int oo);
        vec_t v;
        v.fs = f; v.len = (PW + 1)'(l); v.breq = BB'(b); v.bload = bl;
        v.addr = (BB + PW)'(a); v.run = r; v.done = d; v.ovr = o;
        v.fc = CW'(c); v.oc = CW'(oo);
        vq.push_back(v);
    endtask

    // Reference model: program position, length, bank and counters as plain integers
    bit m_run;
    int m_pc, m_len, m_bank, m_pend, m_fc, m_oc;
    bit m_done, m_ovr;

    task automatic model_begin(input int l, input int b, input bit bl);
        if (l != 0) begin
            m_run = 1; m_pc = 0; m_len = l; m_bank = bl ? b : m_pend;
        end else begin
            m_run = 0; m_pc = 0;
        end
    endtask

    task automatic model_step(input bit f, input int l, input int b, input bit bl);
        m_done = 0; m_ovr = 0;
        if (f) m_fc = (m_fc + 1) % (1 << CW);
        if (m_run) begin
            if (f) begin
                if (m_pc == m_len - 1) m_done = 1;
                else begin
                    m_ovr = 1;
                    if (m_oc < (1 << CW) - 1) m_oc++;
                end
                model_begin(l, b, bl);
            end else if (m_pc == m_len - 1) begin
                m_run = 0; m_done = 1;
            end else begin
                m_pc++;
            end
        end else if (f && l != 0) begin
            model_begin(l, b, bl);
        end
        if (bl) m_pend = b;
    endtask

    initial begin
        reset_n = 1'b0; fs = 1'b0; plen = '0; breq = '0; bload = 1'b0; fr_len = 3;

        // Reset state of both instances
        repeat (3) @(posedge clk);
        #1;
        check("reset addr", 64'(addr), 64'(0));
        check("reset run", 64'(run), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset ovr", 64'(ovr), 64'(0));
        check("reset fc", 64'(fc), 64'(0));
        check("reset oc", 64'(oc), 64'(0));
        check("reset bank", 64'(abank), 64'(0));
        check("reset fr_run", 64'(fr_run), 64'(0));

        // frame_start with prog_len=0 only counts
        do_reset();
        cycle(1, 0, 0, 0);
        check("len0 run", 64'(run), 64'(0));
        cycle(1, 0, 0, 0);
        check("len0 fc", 64'(fc), 64'(2));
        check("len0 run2", 64'(run), 64'(0));

        // Directed vector table: normal frame, end-coincident restart, overrun with bank switch
        add(1, 4, 0, 0,  0, 1, 0, 0, 1, 0);
        add(0, 4, 0, 0,  1, 1, 0, 0, 1, 0);
        add(0, 4, 0, 0,  2, 1, 0, 0, 1, 0);
        add(0, 4, 0, 0,  3, 1, 0, 0, 1, 0);
        add(0, 4, 0, 0,  3, 0, 1, 0, 1, 0);
        add(0, 4, 0, 0,  3, 0, 0, 0, 1, 0);
        add(1, 4, 0, 0,  0, 1, 0, 0, 2, 0);
        add(0, 4, 0, 0,  1, 1, 0, 0, 2, 0);
        add(0, 4, 0, 0,  2, 1, 0, 0, 2, 0);
        add(0, 4, 0, 0,  3, 1, 0, 0, 2, 0);
        add(1, 4, 0, 0,  0, 1, 1, 0, 3, 0);
        add(0, 4, 0, 0,  1, 1, 0, 0, 3, 0);
        add(0, 4, 0, 0,  2, 1, 0, 0, 3, 0);
        add(0, 4, 0, 0,  3, 1, 0, 0, 3, 0);
        add(0, 4, 0, 0,  3, 0, 1, 0, 3, 0);
        add(1, 8, 0, 0,  0, 1, 0, 0, 4, 0);
        add(0, 8, 0, 0,  1, 1, 0, 0, 4, 0);
        add(0, 8, 1, 1,  2, 1, 0, 0, 4, 0);
        add(0, 8, 0, 0,  3, 1, 0, 0, 4, 0);
        add(0, 8, 0, 0,  4, 1, 0, 0, 4, 0);
        add(0, 8, 0, 0,  5, 1, 0, 0, 4, 0);
        add(1, 8, 0, 0, 16, 1, 0, 1, 5, 1);
        add(0, 8, 0, 0, 17, 1, 0, 0, 5, 1);

        do_reset();
        foreach (vq[i]) begin
            cycle(vq[i].fs, vq[i].len, vq[i].breq, vq[i].bload);
            check($sformatf("vec%0d addr", i), 64'(addr), 64'(vq[i].addr));
            check($sformatf("vec%0d run", i), 64'(run), 64'(vq[i].run));
            check($sformatf("vec%0d done", i), 64'(done), 64'(vq[i].done));
            check($sformatf("vec%0d ovr", i), 64'(ovr), 64'(vq[i].ovr));
            check($sformatf("vec%0d fc", i), 64'(fc), 64'(vq[i].fc));
            check($sformatf("vec%0d oc", i), 64'(oc), 64'(vq[i].oc));
        end

        // Full-size program (2^PC_WIDTH instructions) in bank 1
        for (int p = 0; p < 16; p++) begin
            cycle(p == 0, 16, 0, 0);
            check($sformatf("full pc%0d", p), 64'(addr), 64'(16 + p));
        end
        cycle(0, 16, 0, 0);
        check("full done", 64'(done), 64'(1));
        check("full run", 64'(run), 64'(0));
        check("full addr", 64'(addr), 64'(31));

        // Counter limits: 20 starts wrap frame_count, overruns saturate
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1, 8, 0, 0);
        check("sat fc20", 64'(fc), 64'(4));
        check("sat oc", 64'(oc), 64'(15));
        for (int k = 0; k < 3; k++) cycle(1, 8, 0, 0);
        check("sat oc hold", 64'(oc), 64'(15));
        check("sat fc23", 64'(fc), 64'(7));
        check("sat ovr pulse", 64'(ovr), 64'(1));

        // Asynchronous reset mid-frame at pc=2
        do_reset();
        cycle(1, 4, 0, 0);
        cycle(0, 4, 0, 0);
        cycle(0, 4, 0, 0);
        check("mid pc", 64'(addr), 64'(2));
        #2 reset_n = 1'b0;
        #1;
        check("async addr", 64'(addr), 64'(0));
        check("async run", 64'(run), 64'(0));
        check("async fc", 64'(fc), 64'(0));
        check("async fr_addr", 64'(fr_addr), 64'(0));
        @(posedge clk);
        #1;
        check("async done", 64'(done), 64'(0));
        check("async ovr", 64'(ovr), 64'(0));

        // Free-run instance: 0,1,2 repeating, frame_done at each wrap, frame_start ignored
        @(negedge clk);
        reset_n = 1'b1;
        fs = 1'($urandom_range(0, 1));
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("fr%0d addr", k), 64'(fr_addr), 64'(k % 3));
            check($sformatf("fr%0d done", k), 64'(fr_done), 64'((k >= 3 && k % 3 == 0) ? 1 : 0));
            check($sformatf("fr%0d run", k), 64'(fr_run), 64'(1));
            check($sformatf("fr%0d ovr", k), 64'(fr_ovr), 64'(0));
            check($sformatf("fr%0d fc", k), 64'(fr_fc), 64'(k / 3 + 1));
            @(negedge clk);
            fs = 1'($urandom_range(0, 1));
        end

        // Randomized traffic against the model
        do_reset();
        m_run = 0; m_pc = 0; m_len = 0; m_bank = 0; m_pend = 0; m_fc = 0; m_oc = 0;
        for (int k = 0; k < 3000; k++) begin
            bit f, bl;
            int l, b;
            logic [63:0] exp_v, act_v;
            f  = ($urandom_range(0, 5) == 0);
            l  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16))
                                              : int'($urandom_range(1, 6));
            bl = ($urandom_range(0, 7) == 0);
            b  = int'($urandom_range(0, 1));
            cycle(f, (PW + 1)'(l), BB'(b), bl);
            model_step(f, l, b, bl);
            exp_v = {32'd0, 5'(m_bank * 16 + m_pc), m_run, m_done, m_ovr, 4'(m_fc), 4'(m_oc),
                     1'(m_bank), 13'd0};
            act_v = {32'd0, addr, run, done, ovr, fc, oc, abank, 13'd0};
            check($sformatf("rand%0d {addr,run,done,ovr,fc,oc,bank}", k), act_v, exp_v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
